// File: rtl/display_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed seven-segment display: digit select,
// active-low anodes with per-slot blanking and blink, frame tick and blink phase.
module display_scan_ctrl #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [0:3] blink_mask,
    output logic [0:1] sel,
    output logic [0:3] an,
    output logic       frame_tick,
    output logic       blink_phase
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
    localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_q, digit_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d;
    logic [0:3]    an_q, an_d;
    logic          tick_q, tick_d;

    always_comb begin
        presc_d = presc_q;
        digit_d = digit_q;
        frame_d = frame_q;
        phase_d = phase_q;
        tick_d  = 1'b0;
        an_d    = '1;

        if (en) begin
            if (presc_q != PRESC_MAX) begin
                presc_d = presc_q + 1'b1;
            end else begin
                presc_d = '0;
                digit_d = digit_q + 2'd1;
                if (digit_q == 2'd3) begin
                    tick_d = 1'b1;
                    if (frame_q == FRAME_MAX) begin
                        frame_d = '0;
                        phase_d = ~phase_q;
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                end
            end

            // Anodes follow the next-state slot so they never light on a select change.
            if ((presc_d >= BLANK_END) && !(blink_mask[digit_d] && phase_d)) begin
                an_d[digit_d] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            digit_q <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
            an_q    <= '1;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
        end
    end

    assign sel         = digit_q;
    assign an          = an_q;
    assign frame_tick  = tick_q;
    assign blink_phase = phase_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: stimulus queues expected outputs per
// clock, a monitor on the falling edge pops and compares them.
module tb_display_scan_ctrl;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [0:3] blink_mask;
    logic [0:1] sel;
    logic [0:3] an;
    logic       frame_tick;
    logic       blink_phase;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .blink_mask (blink_mask),
        .sel        (sel),
        .an         (an),
        .frame_tick (frame_tick),
        .blink_phase(blink_phase)
    );

    typedef struct {
        string      name;
        logic [0:1] sel;
        logic [0:3] an;
        logic       ft;
        logic       bp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    int   m_d = 0;
    int   m_p = 0;
    int   m_f = 0;
    logic m_bp = 1'b0;

    // Reference scan position advanced once per edge from the inputs about to be sampled.
    task automatic advance(input string name, output exp_t e);
        logic wrap;
        wrap = 1'b0;
        e.an = '1;
        e.ft = 1'b0;
        if (!rst_n) begin
            m_d = 0; m_p = 0; m_f = 0; m_bp = 1'b0;
        end else if (en) begin
            if (m_p < RD - 1) begin
                m_p++;
            end else begin
                m_p = 0;
                if (m_d == 3) wrap = 1'b1;
                m_d = (m_d + 1) % 4;
            end
            if (wrap) begin
                if (m_f == BF - 1) begin
                    m_f = 0;
                    m_bp = ~m_bp;
                end else begin
                    m_f++;
                end
            end
            e.ft = wrap;
            if (m_p >= BC && !(blink_mask[m_d] && m_bp)) e.an[m_d] = 1'b0;
        end
        e.sel  = m_d[1:0];
        e.bp   = m_bp;
        e.name = name;
    endtask

    task automatic step(input string name);
        exp_t e;
        advance(name, e);
        @(posedge clk);
        #1;
        q.push_back(e);
    endtask

    task automatic step_lit(input string name, input logic [0:1] s, input logic [0:3] a,
                            input logic ft, input logic bp);
        exp_t e, lit;
        advance(name, e);
        lit.name = name;
        lit.sel  = s;
        lit.an   = a;
        lit.ft   = ft;
        lit.bp   = bp;
        @(posedge clk);
        #1;
        q.push_back(lit);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (sel !== e.sel || an !== e.an || frame_tick !== e.ft || blink_phase !== e.bp) begin
                    errors++;
                    $display("FAIL %s @%0t: got sel=%b an=%b ft=%b bp=%b, expected sel=%b an=%b ft=%b bp=%b",
                             e.name, $time, sel, an, frame_tick, blink_phase,
                             e.sel, e.an, e.ft, e.bp);
                end
            end
        end
    end

    initial begin
        logic [0:3] lit_an [4];
        logic [1:0] sd;
        lit_an = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

        rst_n      = 1'b0;
        en         = 1'b0;
        blink_mask = '0;
        step_lit("reset", 2'b00, 4'b1111, 1'b0, 1'b0);
        step_lit("reset", 2'b00, 4'b1111, 1'b0, 1'b0);

        // Basic scan: the reset cycle stands for presc 0 of digit 0.
        rst_n = 1'b1;
        en    = 1'b1;
        step_lit("scan_d0_blank", 2'b00, 4'b1111, 1'b0, 1'b0);
        repeat (6) step_lit("scan_d0_lit", 2'b00, lit_an[0], 1'b0, 1'b0);
        for (int d = 1; d < 4; d++) begin
            sd = d[1:0];
            repeat (2) step_lit("scan_blank", sd, 4'b1111, 1'b0, 1'b0);
            repeat (6) step_lit("scan_lit", sd, lit_an[d], 1'b0, 1'b0);
        end
        step_lit("frame_tick", 2'b00, 4'b1111, 1'b1, 1'b0);
        repeat (8) step("scan2");

        // Blink digit 2: phase rises at the end of frame 2, falls after two more.
        blink_mask[2] = 1'b1;
        repeat (24) step("blink_wait");
        repeat (64) step("blink_dark");
        repeat (24) step("blink_lit");

        // Enable drop at digit 1, presc 5.
        repeat (21) step("to_d1p5");
        en = 1'b0;
        repeat (10) step_lit("en_low", 2'b01, 4'b1111, 1'b0, 1'b0);
        en = 1'b1;
        repeat (2) step_lit("en_resume", 2'b01, 4'b1011, 1'b0, 1'b0);
        step_lit("en_next_slot", 2'b10, 4'b1111, 1'b0, 1'b0);

        // Reset at digit 3, presc 4 with blink_phase high.
        repeat (44) step("to_d3p4");
        rst_n = 1'b0;
        step_lit("reset_mid", 2'b00, 4'b1111, 1'b0, 1'b0);
        rst_n = 1'b1;
        step_lit("restart_blank", 2'b00, 4'b1111, 1'b0, 1'b0);
        repeat (6) step_lit("restart_lit", 2'b00, lit_an[0], 1'b0, 1'b0);
        step_lit("restart_d1", 2'b01, 4'b1111, 1'b0, 1'b0);

        // Mid-slot mask change while digit 1 is lit and blink_phase is high.
        repeat (67) step("to_d1p3");
        blink_mask[1] = 1'b1;
        repeat (4) step_lit("mask_change", 2'b01, 4'b1111, 1'b0, 1'b1);
        repeat (8) step("mask_after");
        blink_mask = '0;
        repeat (16) step("mask_clear");

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations pending, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
